// File: rtl/v_instr_queue.sv
// Instruction queue between the scalar core and the vector decoder. Non-vector offers are dropped with a one-cycle illegal pulse.
// Optional same-cycle bypass into an empty queue when V_IQ_BYPASS_EN is defined.
module v_instr_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [31:0]              in_rs1,
   input  logic [31:0]              in_rs2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_rs1,
   output logic [31:0]              out_rs2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     illegal
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   mem_instr [DEPTH];
   logic [31:0]   mem_rs1   [DEPTH];
   logic [31:0]   mem_rs2   [DEPTH];

   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic          illegal_q;

   logic          is_vec;
   logic          empty;
   logic          accept;
   logic          byp;
   logic          push;
   logic          pop_mem;

   always_comb begin
      is_vec = (in_instr[6:0] == 7'h57) || (in_instr[6:0] == 7'h07) ||
               (in_instr[6:0] == 7'h27);
   end

   assign empty    = (count_q == '0);
   assign in_ready = (count_q < DEPTH_C);
   assign accept   = in_valid && in_ready;

`ifdef V_IQ_BYPASS_EN
   // An empty queue forwards a vector offer straight to the decoder.
   assign byp = empty && !flush && in_valid && is_vec;
`else
   assign byp = 1'b0;
`endif

   // A bypassed entry that the decoder takes immediately is never stored.
   assign push    = accept && is_vec && !(byp && out_ready);
   assign pop_mem = out_ready && !empty;

   assign out_valid = !empty || byp;

   always_comb begin
      out_instr = '0;
      out_rs1   = '0;
      out_rs2   = '0;
      if (!empty) begin
         out_instr = mem_instr[head_q];
         out_rs1   = mem_rs1[head_q];
         out_rs2   = mem_rs2[head_q];
      end else if (byp) begin
         out_instr = in_instr;
         out_rs1   = in_rs1;
         out_rs2   = in_rs2;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_instr[tail_q] <= in_instr;
         mem_rs1[tail_q]   <= in_rs1;
         mem_rs2[tail_q]   <= in_rs2;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else if (flush) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         if (push) begin
            tail_q <= tail_q + 1'b1;
         end
         if (pop_mem) begin
            head_q <= head_q + 1'b1;
         end
         count_q   <= count_q + CW'(push) - CW'(pop_mem);
         illegal_q <= accept && !is_vec;
      end
   end

   assign count   = count_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_v_instr_queue.sv
// Self-checking bench for v_instr_queue: directed table, hand sequences and random traffic against a queue model.
module tb_v_instr_queue;

   localparam int DEPTH = 4;
`ifdef V_IQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_rs1 = '0;
   logic [31:0] in_rs2 = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_rs1;
   logic [31:0] out_rs2;
   logic [$clog2(DEPTH):0] count;
   logic        illegal;

   v_instr_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_rs1   (out_rs1),
      .out_rs2   (out_rs2),
      .count     (count),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } entry_t;

   typedef struct {
      bit          iv;
      bit          ordy;
      logic [31:0] instr;
      int          e_count;
      bit          e_ir;
      bit          e_ov;
      bit          e_ill;
      logic [31:0] e_oi;
   } vec_t;

   entry_t mq[$];
   bit     m_ill = 1'b0;
   int     total = 0;
   int     passed = 0;

   function automatic bit is_vec(logic [31:0] i);
      return (i[6:0] == 7'h57) || (i[6:0] == 7'h07) || (i[6:0] == 7'h27);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One clock: drive at negedge, compare against the queue model, advance the model.
   task automatic cycle(bit iv, bit ordy, bit fl, logic [31:0] ins, logic [31:0] r1, logic [31:0] r2);
      bit byp, hs, ov, pushed;
      logic [31:0] ei, e1, e2;
      entry_t e;
      @(negedge clk);
      in_valid = iv; out_ready = ordy; flush = fl;
      in_instr = ins; in_rs1 = r1; in_rs2 = r2;
      #1;
      byp = BYP && (mq.size() == 0) && !fl && iv && is_vec(ins);
      ov  = (mq.size() != 0) || byp;
      if (mq.size() != 0) begin
         ei = mq[0].instr; e1 = mq[0].rs1; e2 = mq[0].rs2;
      end else if (byp) begin
         ei = ins; e1 = r1; e2 = r2;
      end else begin
         ei = '0; e1 = '0; e2 = '0;
      end
      chk("model in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("model out_valid", 32'(out_valid), 32'(ov));
      chk("model out_instr", out_instr, ei);
      chk("model out_rs1", out_rs1, e1);
      chk("model out_rs2", out_rs2, e2);
      chk("model count", 32'(count), 32'(mq.size()));
      chk("model illegal", 32'(illegal), 32'(m_ill));
      hs = iv && (mq.size() < DEPTH);
      pushed = hs && is_vec(ins) && !(byp && ordy);
      if (fl) begin
         mq.delete();
         m_ill = 1'b0;
      end else begin
         if (ordy && mq.size() != 0) void'(mq.pop_front());
         if (pushed) begin
            e.instr = ins; e.rs1 = r1; e.rs2 = r2;
            mq.push_back(e);
         end
         m_ill = hs && !is_vec(ins);
      end
   endtask

   task automatic check_reset_state(string tag);
      chk({tag, " count"}, 32'(count), 32'd0);
      chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " illegal"}, 32'(illegal), 32'd0);
      chk({tag, " out_instr"}, out_instr, 32'd0);
      chk({tag, " out_rs1"}, out_rs1, 32'd0);
      chk({tag, " out_rs2"}, out_rs2, 32'd0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse(string tag);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #2 nrst = 1'b0;
      #1 check_reset_state(tag);
      mq.delete();
      m_ill = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
   endtask

   function automatic logic [31:0] rnd_instr();
      int r;
      logic [6:0] op;
      logic [24:0] hi;
      r  = $urandom_range(0, 9);
      hi = 25'($urandom);
      case (r)
         0, 1, 2: op = 7'h57;
         3, 4:    op = 7'h07;
         5, 6:    op = 7'h27;
         7:       op = 7'h33;
         8:       op = 7'h13;
         default: op = 7'(hi);
      endcase
      return {hi, op};
   endfunction

   vec_t tbl[13];
   localparam logic [31:0] V1 = 32'h0000_1057;
   localparam logic [31:0] V2 = 32'h0000_2007;
   localparam logic [31:0] V3 = 32'h0000_3027;
   localparam logic [31:0] V4 = 32'h0000_4057;
   localparam logic [31:0] V5 = 32'h0000_5057;

   initial begin
      //          iv ordy instr          cnt ir ov   ill oi
      tbl[0]  = '{1, 0, 32'h0000_0033,   0, 1, 0,   0, 32'h0};
      tbl[1]  = '{0, 0, 32'h0,           0, 1, 0,   1, 32'h0};
      tbl[2]  = '{0, 0, 32'h0,           0, 1, 0,   0, 32'h0};
      tbl[3]  = '{1, 0, V1,              0, 1, BYP, 0, BYP ? V1 : 32'h0};
      tbl[4]  = '{1, 0, V2,              1, 1, 1,   0, V1};
      tbl[5]  = '{1, 0, V3,              2, 1, 1,   0, V1};
      tbl[6]  = '{1, 0, V4,              3, 1, 1,   0, V1};
      tbl[7]  = '{1, 0, V5,              4, 0, 1,   0, V1};
      tbl[8]  = '{1, 1, V5,              4, 0, 1,   0, V1};
      tbl[9]  = '{0, 1, 32'h0,           3, 1, 1,   0, V2};
      tbl[10] = '{0, 1, 32'h0,           2, 1, 1,   0, V3};
      tbl[11] = '{0, 1, 32'h0,           1, 1, 1,   0, V4};
      tbl[12] = '{0, 0, 32'h0,           0, 1, 0,   0, 32'h0};

      #3 check_reset_state("por");
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;

      // vadd.vv with the decoder ready
      cycle(1, 1, 0, 32'h0220_8057, 32'd5, 32'd0);
      chk("vadd same-cycle valid", 32'(out_valid), 32'(BYP));
      cycle(0, 1, 0, 32'h0, 32'h0, 32'h0);
      chk("vadd next valid", 32'(out_valid), 32'(!BYP));
      chk("vadd next instr", out_instr, BYP ? 32'h0 : 32'h0220_8057);
      chk("vadd next rs1", out_rs1, BYP ? 32'h0 : 32'd5);
      cycle(0, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("vadd count after pop", 32'(count), 32'd0);

      // fill to full, blocked 5th offer, pop-only when full, drain in order
      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].iv, tbl[i].ordy, 0, tbl[i].instr, tbl[i].instr ^ 32'hA5A5_0000, 32'(i));
         chk($sformatf("tbl[%0d] count", i), 32'(count), 32'(tbl[i].e_count));
         chk($sformatf("tbl[%0d] in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         chk($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("tbl[%0d] illegal", i), 32'(illegal), 32'(tbl[i].e_ill));
         chk($sformatf("tbl[%0d] out_instr", i), out_instr, tbl[i].e_oi);
      end

      // flush with a simultaneous push on count = 3
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, V1 + 32'(i << 12), 32'(i), 32'(i));
      cycle(1, 0, 1, V4, 32'd9, 32'd9);
      chk("pre-flush count", 32'(count), 32'd3);
      cycle(0, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("flush count", 32'(count), 32'd0);
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush out_instr", out_instr, 32'd0);

      // flush cancels a pending illegal pulse
      cycle(1, 0, 1, 32'h0000_0033, 32'h0, 32'h0);
      cycle(0, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("flush clears illegal", 32'(illegal), 32'd0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, V2 + 32'(i << 12), 32'(i), 32'(i));
      reset_pulse("midreset");
      cycle(0, 0, 0, 32'h0, 32'h0, 32'h0);

      // random traffic, alternating between backpressure-heavy and drain-heavy phases
      for (int ph = 0; ph < 6; ph++) begin
         for (int n = 0; n < 120; n++) begin
            bit iv, ordy, fl;
            iv   = $urandom_range(0, 3) != 0;
            ordy = (ph % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl   = $urandom_range(0, 39) == 0;
            cycle(iv, ordy, fl, rnd_instr(), $urandom, $urandom);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
